// File: rtl/fpu_pack_pkg.sv
// Shared format table and helpers for the FPU result packer.
// Formats are described by exponent/fraction widths; the helpers are also used in constant context.
package fpu_pack_pkg;

  typedef enum logic [1:0] {
    FMT_S = 2'b00,
    FMT_D = 2'b01,
    FMT_H = 2'b10,
    FMT_Q = 2'b11
  } fmt_e;

  localparam int NE_S = 8;
  localparam int NF_S = 23;
  localparam int LEN_S = 32;
  localparam int NE_D = 11;
  localparam int NF_D = 52;
  localparam int LEN_D = 64;
  localparam int NE_H = 5;
  localparam int NF_H = 10;
  localparam int LEN_H = 16;
  localparam int NE_Q = 15;
  localparam int NF_Q = 112;
  localparam int LEN_Q = 128;

  function automatic int fmt_len(logic [1:0] fmt);
    case (fmt)
      FMT_S:   return LEN_S;
      FMT_D:   return LEN_D;
      FMT_H:   return LEN_H;
      default: return LEN_Q;
    endcase
  endfunction

  function automatic int fmt_ne(logic [1:0] fmt);
    case (fmt)
      FMT_S:   return NE_S;
      FMT_D:   return NE_D;
      FMT_H:   return NE_H;
      default: return NE_Q;
    endcase
  endfunction

  function automatic int fmt_nf(logic [1:0] fmt);
    return fmt_len(fmt) - 1 - fmt_ne(fmt);
  endfunction

  // Exponent width of the internal FLEN-wide format.
  function automatic int flen_ne(int flen);
    case (flen)
      32:      return NE_S;
      64:      return NE_D;
      default: return NE_Q;
    endcase
  endfunction

  function automatic logic [1:0] fmt_for_len(int flen);
    case (flen)
      32:      return FMT_S;
      64:      return FMT_D;
      default: return FMT_Q;
    endcase
  endfunction

  // Canonical NaN of fmt, NaN-boxed with ones up to flen (bits above flen are zero).
  function automatic logic [127:0] canon_nan(logic [1:0] fmt, int flen);
    logic [127:0] r;
    int len;
    int nf;
    len = fmt_len(fmt);
    nf = fmt_nf(fmt);
    r = '0;
    for (int b = 0; b < 128; b++) begin
      if (b >= len && b < flen) r[b] = 1'b1;
      else if (b >= nf && b < len - 1) r[b] = 1'b1;
      else if (b == nf - 1) r[b] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic fmt_supported(logic [1:0] fmt, int flen, bit half_en);
    return (fmt_len(fmt) <= flen) && ((fmt != FMT_H) || half_en);
  endfunction

endpackage

// File: rtl/fpu_pack_lane.sv
// Combinational pack of one lane: format narrowing, NaN detect and canonical-NaN substitution.
module fpu_pack_lane
  import fpu_pack_pkg::*;
#(
  parameter int FLEN = 64,
  parameter int HALF_EN = 1
) (
  input  logic [FLEN-1:0] u,
  input  logic [1:0]      fmt,
  input  logic            canon,
  output logic [FLEN-1:0] pk,
  output logic            nan
);

  localparam int NE = flen_ne(FLEN);
  localparam int NF = FLEN - 1 - NE;
  localparam logic [FLEN-1:0] CANON_FLEN = FLEN'(canon_nan(fmt_for_len(FLEN), FLEN));

  logic [FLEN-1:0] cand [4];
  logic [FLEN-1:0] cnan [4];
  logic            is_nan;
  logic            supported;

  assign is_nan    = (&u[FLEN-2:NF]) && (|u[NF-1:0]);
  assign supported = fmt_supported(fmt, FLEN, HALF_EN != 0);

  // Exponent narrowing keeps the top bit and the low NE_k-1 bits, matching the unpacker's rebias.
  for (genvar gi = 0; gi < 4; gi++) begin : g_fmt
    localparam int LK  = fmt_len(2'(gi));
    localparam int NEK = fmt_ne(2'(gi));
    localparam int NFK = fmt_nf(2'(gi));
    localparam logic [FLEN-1:0] CN = FLEN'(canon_nan(2'(gi), FLEN));

    assign cnan[gi] = CN;
    if (LK < FLEN) begin : g_narrow
      assign cand[gi] = {{(FLEN-LK){1'b1}}, u[FLEN-1], u[FLEN-2], u[NF+NEK-2:NF], u[NF-1:NF-NFK]};
    end else if (LK == FLEN) begin : g_pass
      assign cand[gi] = u;
    end else begin : g_wide
      assign cand[gi] = CANON_FLEN;
    end
  end

  always_comb begin
    pk  = cand[fmt];
    nan = is_nan && supported;
    if (!supported) pk = CANON_FLEN;
    else if (canon && is_nan) pk = cnan[fmt];
  end

endmodule

// File: rtl/fpu_pack_pipe.sv
// Multi-lane FPU result packer with a registered valid/ready stage and a one-entry skid buffer.
module fpu_pack_pipe
  import fpu_pack_pkg::*;
#(
  parameter int FLEN = 64,
  parameter int NLANES = 1,
  parameter int FMTBITS = 2,
  parameter int HALF_EN = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NLANES*FLEN-1:0] in_unpacked,
  input  logic [FMTBITS-1:0]     in_fmt,
  input  logic                   in_canon,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NLANES*FLEN-1:0] out_packed,
  output logic [NLANES-1:0]      out_nan,
  output logic                   out_fmt_err
);

  localparam int W = NLANES * FLEN;

  logic [W-1:0]      res_packed;
  logic [NLANES-1:0] res_nan;
  logic              res_err;
  logic [1:0]        fmt2;
  logic              accept;

  logic [W-1:0]      out_packed_reg, out_packed_next;
  logic [NLANES-1:0] out_nan_reg, out_nan_next;
  logic              out_err_reg, out_err_next;
  logic              out_valid_reg, out_valid_next;
  logic [W-1:0]      skid_packed_reg, skid_packed_next;
  logic [NLANES-1:0] skid_nan_reg, skid_nan_next;
  logic              skid_err_reg, skid_err_next;
  logic              skid_full_reg, skid_full_next;
  logic              in_ready_reg, in_ready_next;

  assign fmt2    = in_fmt[1:0];
  assign res_err = !fmt_supported(fmt2, FLEN, HALF_EN != 0);
  assign accept  = in_valid && in_ready_reg;

  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    fpu_pack_lane #(.FLEN(FLEN), .HALF_EN(HALF_EN)) u_lane (
      .u     (in_unpacked[gi*FLEN +: FLEN]),
      .fmt   (fmt2),
      .canon (in_canon),
      .pk    (res_packed[gi*FLEN +: FLEN]),
      .nan   (res_nan[gi])
    );
  end

  always_comb begin
    out_packed_next  = out_packed_reg;
    out_nan_next     = out_nan_reg;
    out_err_next     = out_err_reg;
    out_valid_next   = out_valid_reg;
    skid_packed_next = skid_packed_reg;
    skid_nan_next    = skid_nan_reg;
    skid_err_next    = skid_err_reg;
    skid_full_next   = skid_full_reg;
    if (!out_valid_reg || out_ready) begin
      // The skid entry is older than anything on the input, so it drains first.
      if (skid_full_reg) begin
        out_packed_next = skid_packed_reg;
        out_nan_next    = skid_nan_reg;
        out_err_next    = skid_err_reg;
        out_valid_next  = 1'b1;
        if (accept) begin
          skid_packed_next = res_packed;
          skid_nan_next    = res_nan;
          skid_err_next    = res_err;
        end else begin
          skid_full_next = 1'b0;
        end
      end else if (accept) begin
        out_packed_next = res_packed;
        out_nan_next    = res_nan;
        out_err_next    = res_err;
        out_valid_next  = 1'b1;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (accept) begin
      skid_packed_next = res_packed;
      skid_nan_next    = res_nan;
      skid_err_next    = res_err;
      skid_full_next   = 1'b1;
    end
    in_ready_next = !skid_full_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_packed_reg  <= '0;
      out_nan_reg     <= '0;
      out_err_reg     <= 1'b0;
      out_valid_reg   <= 1'b0;
      skid_packed_reg <= '0;
      skid_nan_reg    <= '0;
      skid_err_reg    <= 1'b0;
      skid_full_reg   <= 1'b0;
      in_ready_reg    <= 1'b1;
    end else begin
      out_packed_reg  <= out_packed_next;
      out_nan_reg     <= out_nan_next;
      out_err_reg     <= out_err_next;
      out_valid_reg   <= out_valid_next;
      skid_packed_reg <= skid_packed_next;
      skid_nan_reg    <= skid_nan_next;
      skid_err_reg    <= skid_err_next;
      skid_full_reg   <= skid_full_next;
      in_ready_reg    <= in_ready_next;
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign out_packed  = out_packed_reg;
  assign out_nan     = out_nan_reg;
  assign out_fmt_err = out_err_reg;

endmodule

// File: tb/tb_fpu_pack_pipe.sv
// Directed bench for fpu_pack_pipe (FLEN=64, NLANES=2) with a scoreboard queue of expected outputs.
module tb_fpu_pack_pipe;

  localparam int FLEN = 64;
  localparam int NLANES = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   in_unpacked;
  logic [1:0]     in_fmt;
  logic           in_canon;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   out_packed;
  logic [1:0]     out_nan;
  logic           out_fmt_err;

  typedef struct {
    logic [127:0] pk;
    logic [1:0]   nan;
    logic         err;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp;
  int total = 0;
  int bad = 0;
  logic [127:0] held;

  fpu_pack_pipe #(.FLEN(FLEN), .NLANES(NLANES), .FMTBITS(2), .HALF_EN(1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_unpacked (in_unpacked),
    .in_fmt      (in_fmt),
    .in_canon    (in_canon),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_packed  (out_packed),
    .out_nan     (out_nan),
    .out_fmt_err (out_fmt_err)
  );

  always #5 clk = ~clk;

  // Reference behaviour for a 64-bit lane, written out per format.
  function automatic logic [63:0] model_lane(input logic [63:0] u, input logic [1:0] f,
                                             input logic c, output logic n);
    logic isn;
    isn = (u[62:52] == 11'h7FF) && (u[51:0] != 52'd0);
    n = isn;
    case (f)
      2'b00: return (c && isn) ? 64'hFFFFFFFF7FC00000
                               : {32'hFFFFFFFF, u[63], u[62], u[58:52], u[51:29]};
      2'b01: return (c && isn) ? 64'h7FF8000000000000 : u;
      2'b10: return (c && isn) ? 64'hFFFFFFFFFFFF7E00
                               : {48'hFFFFFFFFFFFF, u[63], u[62], u[55:52], u[51:42]};
      default: begin
        n = 1'b0;
        return 64'h7FF8000000000000;
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic check_out();
    exp_t e;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL sb_empty: got=unexpected output %h want=no output", out_packed);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("packed", out_packed, e.pk);
      chk("nan", 128'(out_nan), 128'(e.nan));
      chk("fmt_err", 128'(out_fmt_err), 128'(e.err));
      $display("txn out: packed=%h nan=%b err=%b", out_packed, out_nan, out_fmt_err);
    end
  endtask

  // One clock: observe handshakes on stable signals, then advance to the next falling edge.
  task automatic step(output logic acc);
    logic fire;
    acc = in_valid && in_ready;
    fire = out_valid && out_ready;
    if (fire) check_out();
    if (acc) sb.push_back(cur_exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic [63:0] l0, input logic [63:0] l1, input logic [1:0] f,
                        input logic c);
    logic n0, n1;
    in_unpacked = {l1, l0};
    in_fmt = f;
    in_canon = c;
    in_valid = 1'b1;
    cur_exp.pk = {model_lane(l1, f, c, n1), model_lane(l0, f, c, n0)};
    cur_exp.nan = {n1, n0};
    cur_exp.err = (f == 2'b11);
  endtask

  task automatic wait_accept();
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) step(acc);
    total++;
    assert (acc) else begin
      bad++;
      $error("FAIL accept_timeout: got=not accepted want=accepted");
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [63:0] l0, input logic [63:0] l1, input logic [1:0] f,
                      input logic c);
    set_in(l0, l1, f, c);
    wait_accept();
  endtask

  // Directed case whose expectation comes from hand-derived constants.
  task automatic send_e(input logic [63:0] l0, input logic [63:0] l1, input logic [1:0] f,
                        input logic c, input logic [127:0] pk, input logic [1:0] n,
                        input logic err);
    set_in(l0, l1, f, c);
    cur_exp.pk = pk;
    cur_exp.nan = n;
    cur_exp.err = err;
    wait_accept();
  endtask

  task automatic drain();
    logic acc;
    in_valid = 1'b0;
    for (int n = 0; n < 10 && sb.size() != 0; n++) step(acc);
    step(acc);
    chk("drain_empty", 128'(sb.size()), 128'd0);
    chk("idle_valid", 128'(out_valid), 128'd0);
  endtask

  initial begin
    logic acc;
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_unpacked = '0;
    in_fmt = 2'b00;
    in_canon = 1'b0;
    out_ready = 1'b1;
    cur_exp = '{pk: '0, nan: '0, err: 1'b0};

    @(negedge clk);
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_packed", out_packed, 128'd0);
    chk("rst_nan", 128'(out_nan), 128'd0);
    chk("rst_err", 128'(out_fmt_err), 128'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 128'(in_ready), 128'd1);

    // Single and half narrowing, double passthrough.
    send_e(64'h3FF0000000000000, 64'hC000000000000000, 2'b00, 1'b0,
           {64'hFFFFFFFFC0000000, 64'hFFFFFFFF3F800000}, 2'b00, 1'b0);
    send_e(64'h3FF0000000000000, 64'hC000000000000000, 2'b10, 1'b0,
           {64'hFFFFFFFFFFFFC000, 64'hFFFFFFFFFFFF3C00}, 2'b00, 1'b0);
    send_e(64'h3FF0000000000000, 64'hC000000000000000, 2'b01, 1'b0,
           {64'hC000000000000000, 64'h3FF0000000000000}, 2'b00, 1'b0);
    // NaN handling with and without canonicalisation.
    send_e(64'h7FF0000000000001, 64'h3FF0000000000000, 2'b00, 1'b1,
           {64'hFFFFFFFF3F800000, 64'hFFFFFFFF7FC00000}, 2'b01, 1'b0);
    send_e(64'h7FF0000000000001, 64'h3FF0000000000000, 2'b00, 1'b0,
           {64'hFFFFFFFF3F800000, 64'hFFFFFFFF7F800000}, 2'b01, 1'b0);
    send_e(64'hFFF0000000000005, 64'h7FF0000000000000, 2'b01, 1'b1,
           {64'h7FF0000000000000, 64'h7FF8000000000000}, 2'b01, 1'b0);
    send_e(64'hFFF0000000000005, 64'h7FF8000000000123, 2'b01, 1'b0,
           {64'h7FF8000000000123, 64'hFFF0000000000005}, 2'b11, 1'b0);
    // Quad is wider than FLEN: error with canonical double NaN, NaN flags suppressed.
    send_e(64'h7FF0000000000001, 64'h3FF0000000000000, 2'b11, 1'b0,
           {64'h7FF8000000000000, 64'h7FF8000000000000}, 2'b00, 1'b1);
    drain();

    // Stall: A to output, B to skid, C blocked.
    out_ready = 1'b0;
    send(64'h4000000000000000, 64'h3FE8000000000000, 2'b00, 1'b0);
    send(64'h400921FB54442D18, 64'hBFF0000000000000, 2'b10, 1'b0);
    chk("ready_drop", 128'(in_ready), 128'd0);
    held = out_packed;
    set_in(64'h7FF4000000000000, 64'h0000000000000001, 2'b00, 1'b1);
    step(acc);
    chk("stall_acc", 128'(acc), 128'd0);
    chk("stall_stable", out_packed, held);
    chk("stall_ready", 128'(in_ready), 128'd0);
    out_ready = 1'b1;
    wait_accept();
    drain();

    // Back-to-back stream with out_ready held high.
    for (int i = 0; i < 10; i++) begin
      chk("stream_ready", 128'(in_ready), 128'd1);
      set_in({$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));
      step(acc);
      chk("stream_acc", 128'(acc), 128'd1);
    end
    drain();

    // Asynchronous reset with output and skid both full.
    out_ready = 1'b0;
    send(64'h3FF0000000000000, 64'h3FF0000000000000, 2'b00, 1'b0);
    send(64'hC000000000000000, 64'hC000000000000000, 2'b01, 1'b0);
    chk("full_ready", 128'(in_ready), 128'd0);
    chk("full_valid", 128'(out_valid), 128'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 128'(out_valid), 128'd0);
    chk("arst_packed", out_packed, 128'd0);
    chk("arst_nan", 128'(out_nan), 128'd0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("arst_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;
    send_e(64'h3FF0000000000000, 64'hC000000000000000, 2'b00, 1'b0,
           {64'hFFFFFFFFC0000000, 64'hFFFFFFFF3F800000}, 2'b00, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
